// File: rtl/prism_aux_pkg.sv
// rtl/prism_aux_pkg.sv - shared register map, CTRL field offsets and IRQ bit indices for prism_aux_unit
package prism_aux_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRELOAD  = 3'd1;
  localparam logic [2:0] ADDR_COMPARE  = 3'd2;
  localparam logic [2:0] ADDR_SHIFT    = 3'd3;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd4;
  localparam logic [2:0] ADDR_COUNT    = 3'd5;

  localparam int CTRL_DIR       = 0;
  localparam int CTRL_SRC       = 1;
  localparam int CTRL_LEN_LSB   = 2;
  localparam int CTRL_INSEL_LSB = 7;
  localparam int CTRL_IRQEN_LSB = 9;
  localparam int CTRL_AUTO      = 12;
  localparam int CTRL_W         = 13;

  localparam int IRQ_ZERO  = 0;
  localparam int IRQ_MATCH = 1;
  localparam int IRQ_EVENT = 2;

  // Shift counter width; wide enough for any CNT1_W up to 64.
  localparam int SCNT_W = 6;

  // Last shift-counter value before wrap; a zero length means the full register width.
  function automatic logic [SCNT_W-1:0] shift_last(input logic [4:0] len, input logic src,
                                                   input int shift_w, input int cnt1_w);
    if (len == 5'd0) begin
      return src ? SCNT_W'(cnt1_w - 1) : SCNT_W'(shift_w - 1);
    end
    return SCNT_W'(len) - SCNT_W'(1);
  endfunction

endpackage

// File: rtl/prism_aux_shifter.sv
// rtl/prism_aux_shifter.sv - comm_data shift register, shift counter and shift_bit selection
module prism_aux_shifter
  import prism_aux_pkg::*;
#(
  parameter int SHIFT_W = 8,
  parameter int CNT1_W  = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
  input  logic               shift_stb,
  input  logic               shift_src,
  input  logic               shift_dir,
  input  logic [4:0]         shift_len,
  input  logic               ser_bit,
  input  logic               cnt1_msb,
  input  logic               wr_shift,
  input  logic [SHIFT_W-1:0] wr_value,
  output logic [SHIFT_W-1:0] comm_data,
  output logic               shift_bit,
  output logic               shift_done
);

  logic [SCNT_W-1:0] scnt;
  logic [SCNT_W-1:0] last;
  logic              stb;

  assign stb  = exec & shift_stb;
  assign last = shift_last(shift_len, shift_src, SHIFT_W, CNT1_W);

  // Host write beats a same-cycle shift; the counter advances on every accepted strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      comm_data <= '0;
      scnt      <= '0;
    end else begin
      if (wr_shift) begin
        comm_data <= wr_value;
      end else if (stb && !shift_src) begin
        comm_data <= shift_dir ? {ser_bit, comm_data[SHIFT_W-1:1]}
                               : {comm_data[SHIFT_W-2:0], ser_bit};
      end
      if (stb) begin
        scnt <= (scnt >= last) ? '0 : scnt + SCNT_W'(1);
      end
    end
  end

  assign shift_bit  = shift_src ? cnt1_msb
                                : (shift_dir ? comm_data[0] : comm_data[SHIFT_W-1]);
  assign shift_done = (scnt == '0);

endmodule

// File: rtl/prism_aux_unit.sv
// rtl/prism_aux_unit.sv - FSM aux counters, shifter, host regs and irq; option macro PRISM_AUX_AUTORELOAD_EN
module prism_aux_unit
  import prism_aux_pkg::*;
#(
  parameter int CNT1_W  = 24,
  parameter int CNT2_W  = 8,
  parameter int SHIFT_W = 8,
  parameter int IN_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exec,
  input  logic            cnt1_load,
  input  logic            cnt1_dec,
  input  logic            cnt2_inc,
  input  logic            cnt2_clr,
  input  logic            shift_stb,
  input  logic [IN_W-1:0] ser_in,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [31:0]     wr_data,
  input  logic [2:0]      rd_addr,
  output logic [31:0]     rd_data,
  output logic            cnt1_zero,
  output logic            cnt2_match,
  output logic            shift_done,
  output logic            shift_bit,
  output logic            irq
);

`ifdef PRISM_AUX_AUTORELOAD_EN
  localparam logic [CTRL_W-1:0] CTRL_MASK = '1;
`else
  localparam logic [CTRL_W-1:0] CTRL_MASK = ~(CTRL_W'(1) << CTRL_AUTO);
`endif

  logic [CTRL_W-1:0]  ctrl_q;
  logic [CNT1_W-1:0]  preload_q;
  logic [CNT2_W-1:0]  compare_q;
  logic [CNT1_W-1:0]  count1_q;
  logic [CNT2_W-1:0]  count2_q;
  logic [2:0]         irq_stat_q;
  logic               zero_prev_q;
  logic               match_prev_q;
  logic [SHIFT_W-1:0] comm_data;

  logic       shift_dir, shift_src;
  logic [4:0] shift_len;
  logic [1:0] in_sel;
  logic [2:0] irq_en;
  logic       ser_bit;
  logic       reload_hit;
  logic [2:0] irq_set;
  logic       wr_ctrl, wr_preload, wr_compare, wr_shift, wr_irq;
  logic [CNT2_W+CNT1_W-1:0] count_cat;
  logic       unused_ok;

  assign shift_dir = ctrl_q[CTRL_DIR];
  assign shift_src = ctrl_q[CTRL_SRC];
  assign shift_len = ctrl_q[CTRL_LEN_LSB +: 5];
  assign in_sel    = ctrl_q[CTRL_INSEL_LSB +: 2];
  assign irq_en    = ctrl_q[CTRL_IRQEN_LSB +: 3];

  assign wr_ctrl    = wr_en && (wr_addr == ADDR_CTRL);
  assign wr_preload = wr_en && (wr_addr == ADDR_PRELOAD);
  assign wr_compare = wr_en && (wr_addr == ADDR_COMPARE);
  assign wr_shift   = wr_en && (wr_addr == ADDR_SHIFT);
  assign wr_irq     = wr_en && (wr_addr == ADDR_IRQ_STAT);

  assign unused_ok = ^wr_data;

  // Serial input mux; out-of-range selections read as 0.
  always_comb begin
    ser_bit = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (int'(in_sel) == i) ser_bit = ser_in[i];
    end
  end

`ifdef PRISM_AUX_AUTORELOAD_EN
  assign reload_hit = exec && cnt1_dec && !cnt1_load && ctrl_q[CTRL_AUTO]
                      && (count1_q == CNT1_W'(1));
`else
  assign reload_hit = 1'b0;
`endif

  assign cnt1_zero  = (count1_q == '0);
  assign cnt2_match = (count2_q == compare_q);

  // Auto-reload never lets count1 reach 0, so its reload counts as the zero event instead.
  assign irq_set[IRQ_ZERO]  = (cnt1_zero && !zero_prev_q) || reload_hit;
  assign irq_set[IRQ_MATCH] = cnt2_match && !match_prev_q;
  assign irq_set[IRQ_EVENT] = exec && cnt2_inc && cnt2_clr;

  // Host-writable configuration registers; new values are seen by the counters next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      preload_q <= '0;
      compare_q <= '0;
    end else begin
      if (wr_ctrl)    ctrl_q    <= wr_data[CTRL_W-1:0] & CTRL_MASK;
      if (wr_preload) preload_q <= wr_data[CNT1_W-1:0];
      if (wr_compare) compare_q <= wr_data[CNT2_W-1:0];
    end
  end

  // Countdown counter; load+dec together captures comm_data, otherwise it may shift serially.
  always_ff @(posedge clk) begin
    if (rst) begin
      count1_q <= '0;
    end else if (exec) begin
      if (cnt1_load && !cnt1_dec) begin
        count1_q <= preload_q;
      end else if (cnt1_dec && !cnt1_load) begin
        if (reload_hit)            count1_q <= preload_q;
        else if (count1_q != '0)   count1_q <= count1_q - CNT1_W'(1);
      end else if (cnt1_load && cnt1_dec) begin
        count1_q <= CNT1_W'(comm_data);
      end else if (shift_stb && shift_src) begin
        count1_q <= {count1_q[CNT1_W-2:0], ser_bit};
      end
    end
  end

  // Event counter; inc+clr together holds the value and flags an event instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      count2_q <= '0;
    end else if (exec) begin
      if (cnt2_clr && !cnt2_inc)      count2_q <= '0;
      else if (cnt2_inc && !cnt2_clr) count2_q <= count2_q + CNT2_W'(1);
    end
  end

  // Sticky status with W1C; a same-cycle set wins. Edge detectors reset to the flags' reset level.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_stat_q   <= '0;
      zero_prev_q  <= 1'b1;
      match_prev_q <= 1'b1;
      irq          <= 1'b0;
    end else begin
      irq_stat_q   <= (wr_irq ? (irq_stat_q & ~wr_data[2:0]) : irq_stat_q) | irq_set;
      zero_prev_q  <= cnt1_zero;
      match_prev_q <= cnt2_match;
      irq          <= |(irq_stat_q & irq_en);
    end
  end

  prism_aux_shifter #(
    .SHIFT_W (SHIFT_W),
    .CNT1_W  (CNT1_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .exec       (exec),
    .shift_stb  (shift_stb),
    .shift_src  (shift_src),
    .shift_dir  (shift_dir),
    .shift_len  (shift_len),
    .ser_bit    (ser_bit),
    .cnt1_msb   (count1_q[CNT1_W-1]),
    .wr_shift   (wr_shift),
    .wr_value   (wr_data[SHIFT_W-1:0]),
    .comm_data  (comm_data),
    .shift_bit  (shift_bit),
    .shift_done (shift_done)
  );

  assign count_cat = {count2_q, count1_q};

  // Combinational host read; unmapped addresses return 0.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_CTRL:     rd_data = 32'(ctrl_q);
      ADDR_PRELOAD:  rd_data = 32'(preload_q);
      ADDR_COMPARE:  rd_data = 32'(compare_q);
      ADDR_SHIFT:    rd_data = 32'(comm_data);
      ADDR_IRQ_STAT: rd_data = 32'(irq_stat_q);
      ADDR_COUNT:    rd_data = 32'(count_cat);
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_prism_aux_unit.sv
// tb/tb_prism_aux_unit.sv - scoreboard bench for prism_aux_unit; honours PRISM_AUX_AUTORELOAD_EN
module tb_prism_aux_unit;

  logic        clk = 1'b0;
  logic        rst, exec, cnt1_load, cnt1_dec, cnt2_inc, cnt2_clr, shift_stb;
  logic [3:0]  ser_in;
  logic        wr_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic        cnt1_zero, cnt2_match, shift_done, shift_bit, irq;

  localparam int S_RD = 0, S_ZERO = 1, S_MATCH = 2, S_DONE = 3, S_BIT = 4, S_IRQ = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } item_t;

  item_t       sb[$];
  item_t       cur;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  int b_msb[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int b_lsb[4] = '{0, 0, 1, 1};
`ifdef PRISM_AUX_AUTORELOAD_EN
  int          ar_exp[4] = '{1, 2, 1, 2};
  logic [31:0] ctrl_rb   = 32'h0000_1FFF;
`else
  int          ar_exp[4] = '{1, 0, 0, 0};
  logic [31:0] ctrl_rb   = 32'h0000_0FFF;
`endif

  always #5 clk = ~clk;

  prism_aux_unit dut (
    .clk        (clk),
    .rst        (rst),
    .exec       (exec),
    .cnt1_load  (cnt1_load),
    .cnt1_dec   (cnt1_dec),
    .cnt2_inc   (cnt2_inc),
    .cnt2_clr   (cnt2_clr),
    .shift_stb  (shift_stb),
    .ser_in     (ser_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cnt1_zero  (cnt1_zero),
    .cnt2_match (cnt2_match),
    .shift_done (shift_done),
    .shift_bit  (shift_bit),
    .irq        (irq)
  );

  // Monitor: every expectation queued during a cycle is compared at that cycle's falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.sig)
        S_RD:    act = rd_data;
        S_ZERO:  act = {31'd0, cnt1_zero};
        S_MATCH: act = {31'd0, cnt2_match};
        S_DONE:  act = {31'd0, shift_done};
        S_BIT:   act = {31'd0, shift_bit};
        S_IRQ:   act = {31'd0, irq};
        default: act = 'x;
      endcase
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s actual=0x%08h expected=0x%08h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic clr_in();
    cnt1_load = 0; cnt1_dec = 0; cnt2_inc = 0; cnt2_clr = 0; shift_stb = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    clr_in();
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
  endtask

  task automatic exp_sig(input string n, input int s, input logic [31:0] v);
    item_t it;
    it.name = n; it.sig = s; it.exp = v;
    sb.push_back(it);
  endtask

  task automatic exp_rd(input string n, input logic [2:0] a, input logic [31:0] v);
    rd_addr = a;
    exp_sig(n, S_RD, v);
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; exec = 0; ser_in = 0; rd_addr = 0;
    clr_in();
    step(); step();
    rst = 0;

    // reset state
    exp_sig("rst_zero", S_ZERO, 1);
    exp_sig("rst_match", S_MATCH, 1);
    exp_sig("rst_done", S_DONE, 1);
    exp_sig("rst_irq", S_IRQ, 0);
    for (int a = 0; a < 8; a++) exp_rd($sformatf("rst_rd%0d", a), 3'(a), 0);

    exec = 1;
    host_wr(3'd6, 32'hFFFF_FFFF);
    exp_rd("unmapped6", 3'd6, 0);
    host_wr(3'd0, 32'hFFFF_FFFF);
    exp_rd("ctrl_mask", 3'd0, ctrl_rb);

    // countdown to zero, status and irq latency
    host_wr(3'd0, 32'h200);
    host_wr(3'd1, 5);
    cnt1_load = 1; step();
    exp_rd("load5", 3'd5, 5);
    for (int i = 4; i >= 0; i--) begin
      cnt1_dec = 1; step();
      exp_sig($sformatf("zero_flag%0d", i), S_ZERO, 32'(i == 0));
      exp_rd($sformatf("dec_to%0d", i), 3'd5, 32'(i));
    end
    step();
    exp_sig("irq_lat0", S_IRQ, 0);
    exp_rd("stat_zero", 3'd4, 1);
    step();
    exp_sig("irq_set", S_IRQ, 1);
    sample();
    host_wr(3'd4, 1);
    exp_rd("w1c_clear", 3'd4, 0);
    step();
    exp_sig("irq_clr", S_IRQ, 0);
    sample();

    // set beats same-cycle W1C
    host_wr(3'd1, 1);
    cnt1_load = 1; step();
    cnt1_dec = 1; step();
    wr_en = 1; wr_addr = 3'd4; wr_data = 1; step();
    exp_rd("w1c_vs_set", 3'd4, 1);
    host_wr(3'd4, 1);
    exp_rd("w1c_after", 3'd4, 0);

    // event counter, compare match, inc+clr event, wrap
    host_wr(3'd2, 3);
    for (int i = 0; i < 3; i++) begin
      cnt2_inc = 1; step();
      exp_sig($sformatf("match_%0d", i), S_MATCH, 32'(i == 2));
      sample();
    end
    exp_rd("cnt2_3", 3'd5, 32'h0300_0000);
    cnt2_inc = 1; cnt2_clr = 1; step();
    exp_rd("inc_clr_hold", 3'd5, 32'h0300_0000);
    exp_rd("stat_match_evt", 3'd4, 6);
    cnt2_clr = 1; step();
    exp_rd("cnt2_clr", 3'd5, 0);
    for (int i = 0; i < 257; i++) begin
      cnt2_inc = 1; step();
    end
    exp_rd("cnt2_wrap", 3'd5, 32'h0100_0000);
    host_wr(3'd4, 7);
    exp_rd("stat_clr_all", 3'd4, 0);

    // MSB-first 8-bit shift of 0xA5 with ones shifted in
    host_wr(3'd0, 32'h20);
    host_wr(3'd3, 32'hA5);
    ser_in = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      exp_sig($sformatf("msb_bit%0d", i), S_BIT, 32'(b_msb[i]));
      exp_sig($sformatf("msb_done%0d", i), S_DONE, 32'(i == 0));
      sample();
      shift_stb = 1; step();
    end
    exp_sig("msb_done_end", S_DONE, 1);
    exp_rd("msb_data", 3'd3, 32'hFF);

    // LSB-first 4-bit shift from pin 2
    host_wr(3'd0, 32'h111);
    host_wr(3'd3, 32'h0C);
    ser_in = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      exp_sig($sformatf("lsb_bit%0d", i), S_BIT, 32'(b_lsb[i]));
      exp_sig($sformatf("lsb_done%0d", i), S_DONE, 32'(i == 0));
      sample();
      shift_stb = 1; step();
    end
    exp_sig("lsb_done_end", S_DONE, 1);
    exp_rd("lsb_data", 3'd3, 32'hF0);

    // load+dec takes comm_data, then one shift through count1
    cnt1_load = 1; cnt1_dec = 1; step();
    exp_rd("load_dec_comm", 3'd5, 32'h0100_00F0);
    host_wr(3'd0, 32'h2);
    shift_stb = 1; step();
    exp_rd("src_shift_cnt", 3'd5, 32'h0100_01E0);
    exp_rd("src_shift_keep", 3'd3, 32'hF0);

    // reset mid-shift with irq pending
    cnt2_inc = 1; cnt2_clr = 1; step();
    host_wr(3'd0, 32'hE20);
    step();
    exp_sig("irq_pre_rst", S_IRQ, 1);
    sample();
    shift_stb = 1; step();
    shift_stb = 1; step();
    exp_sig("mid_shift_done", S_DONE, 0);
    sample();
    rst = 1; shift_stb = 1; cnt2_inc = 1; step();
    rst = 0;
    exp_sig("rst2_zero", S_ZERO, 1);
    exp_sig("rst2_match", S_MATCH, 1);
    exp_sig("rst2_done", S_DONE, 1);
    exp_sig("rst2_irq", S_IRQ, 0);
    for (int a = 0; a < 6; a++) exp_rd($sformatf("rst2_rd%0d", a), 3'(a), 0);

    // auto-reload (or plain stop at zero when the option is absent)
    host_wr(3'd0, 32'h1000);
    host_wr(3'd1, 2);
    cnt1_load = 1; step();
    exp_rd("ar_load", 3'd5, 2);
    for (int i = 0; i < 4; i++) begin
      cnt1_dec = 1; step();
      exp_rd($sformatf("ar_dec%0d", i), 3'd5, 32'(ar_exp[i]));
    end
    step();
    exp_rd("ar_zero_evt", 3'd4, 1);

    step();
    if (checks < 12) begin
        errors++;
        $display("FAIL check_count actual=%0d expected>=12", checks);
    end
    if (errors != 0) begin
        $display("FAIL summary errors=%0d", errors);
    end else begin
        $display("PASS");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
